// File: rtl/merge_escrita_memoria.sv
// merge_escrita_memoria
//
// Turns a sub-word (or unaligned full-word) store into a read-modify-write on a
// word-wide memory. A full, aligned store goes straight to a write. Anything
// else reads the addressed word, waits MEM_LATENCY cycles, then writes back.
// The store's bytes replace part of that word, and the rest of the word is kept.
// Bytes that would cross into the next word are dropped.
//
// Handshake: a request is taken on a rising edge where req_valid=1 and
// req_ready=1. req_ready is high only while idle (OCIOSO), so req_valid held
// during an operation is ignored. Addr/size/data are latched at that edge.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_addr              byte address of the store
//   req_size              00=DATA_W, 01=32b, 10=16b, 11=8b
//   req_data              store data, right-aligned
//   mem_addr              word-aligned memory address
//   mem_rd / mem_rdata    read strobe / read data (captured when leaving ESPERA)
//   mem_wr / mem_wdata    write strobe / merged word (zero when not writing)
//   done                  one-cycle completion pulse
//   erro_alinh            misalignment flag, qualified by done
//
// Optional feature: define MERGE_ALINH_TRAP_EN to reject requests whose byte
// offset is not a multiple of the store size. Such a request goes straight to
// FIM with erro_alinh=1 and makes no memory access. Without the macro,
// erro_alinh is tied to 0 and misaligned stores are merged.

module merge_escrita_memoria #(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 64,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [DATA_W-1:0] req_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              done,
    output logic              erro_alinh
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {
        OCIOSO,
        LEITURA,
        ESPERA,
        ESCRITA,
        FIM
    } estado_t;

    estado_t           estado_q, estado_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [1:0]        size_q,   size_d;
    logic [DATA_W-1:0] data_q,   data_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
`ifdef MERGE_ALINH_TRAP_EN
    logic              erro_q,   erro_d;
`endif

    // On a 16-bit memory a 32-bit store covers the whole word and more.
    // It is handled exactly like a full-word store.
    function automatic logic [1:0] eff_size(input logic [1:0] s);
        if (DATA_W == 16 && s == 2'b01) begin
            return 2'b00;
        end
        return s;
    endfunction

    function automatic int bytes_of(input logic [1:0] s);
        case (s)
            2'b00:   return NB;
            2'b01:   return 4;
            2'b10:   return 2;
            default: return 1;
        endcase
    endfunction

    // Merge of the latched store into the word arriving on mem_rdata.
    // The data is shifted up to its byte offset. A byte lane takes store data
    // only inside [off, off+n-1]. Lanes past the top of the word do not exist,
    // so the overflow bytes are dropped.
    logic [DATA_W-1:0] merged;
    always_comb begin
        int                off_i;
        int                n_i;
        logic [DATA_W-1:0] shifted;
        off_i   = int'(addr_q[OFF_W-1:0]);
        n_i     = bytes_of(size_q);
        shifted = data_q << (8 * off_i);
        for (int i = 0; i < NB; i++) begin
            if (i >= off_i && i < off_i + n_i) begin
                merged[8*i +: 8] = shifted[8*i +: 8];
            end else begin
                merged[8*i +: 8] = mem_rdata[8*i +: 8];
            end
        end
    end

    // Next-state and datapath register updates
    always_comb begin
        logic [1:0] sz_in;
        int         off_in;
`ifdef MERGE_ALINH_TRAP_EN
        int         n_in;
`endif
        estado_d = estado_q;
        addr_d   = addr_q;
        size_d   = size_q;
        data_d   = data_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
`ifdef MERGE_ALINH_TRAP_EN
        erro_d   = erro_q;
        n_in     = bytes_of(eff_size(req_size));
`endif
        sz_in    = eff_size(req_size);
        off_in   = int'(req_addr[OFF_W-1:0]);

        case (estado_q)
            OCIOSO: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    size_d = sz_in;
                    data_d = req_data;
                    cnt_d  = '0;
`ifdef MERGE_ALINH_TRAP_EN
                    erro_d = 1'b0;
                    if ((off_in % n_in) != 0) begin
                        erro_d   = 1'b1;
                        estado_d = FIM;
                    end else
`endif
                    if (sz_in == 2'b00 && off_in == 0) begin
                        wdata_d  = req_data;
                        estado_d = ESCRITA;
                    end else begin
                        estado_d = LEITURA;
                    end
                end
            end
            LEITURA: begin
                cnt_d    = '0;
                estado_d = ESPERA;
            end
            ESPERA: begin
                if (cnt_q == CNT_LAST) begin
                    wdata_d  = merged;
                    cnt_d    = '0;
                    estado_d = ESCRITA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ESCRITA: estado_d = FIM;
            FIM:     estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q <= OCIOSO;
            addr_q   <= '0;
            size_q   <= '0;
            data_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
`ifdef MERGE_ALINH_TRAP_EN
            erro_q   <= 1'b0;
`endif
        end else begin
            estado_q <= estado_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            data_q   <= data_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
`ifdef MERGE_ALINH_TRAP_EN
            erro_q   <= erro_d;
`endif
        end
    end

    // Outputs are decoded from the state register.
    // Read and write strobes come from different states, so they never overlap.
    always_comb begin
        req_ready = (estado_q == OCIOSO);
        mem_rd    = (estado_q == LEITURA);
        mem_wr    = (estado_q == ESCRITA);
        done      = (estado_q == FIM);
        mem_wdata = (estado_q == ESCRITA) ? wdata_q : '0;
        mem_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
`ifdef MERGE_ALINH_TRAP_EN
        erro_alinh = (estado_q == FIM) && erro_q;
`else
        erro_alinh = 1'b0;
`endif
    end

endmodule

// File: tb/tb_merge_escrita_memoria.sv
// Bench for merge_escrita_memoria: DATA_W=64, ADDR_W=64, MEM_LATENCY=3.
// The memory model returns the stored word only in the cycle that is
// MEM_LATENCY cycles after the read strobe, and random noise at other times.
// Expected words and latencies come from a byte-array model of the store.

module tb_merge_escrita_memoria;

    localparam int DW  = 64;
    localparam int AW  = 64;
    localparam int LAT = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr = '0;
    logic [1:0]    req_size = '0;
    logic [DW-1:0] req_data = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [DW-1:0] mem_rdata;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;
    logic          done;
    logic          erro_alinh;

    int total = 0;
    int bad   = 0;

    merge_escrita_memoria #(.DATA_W(DW), .ADDR_W(AW), .MEM_LATENCY(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_data   (req_data),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .mem_wr     (mem_wr),
        .mem_wdata  (mem_wdata),
        .done       (done),
        .erro_alinh (erro_alinh)
    );

    // clock / reset
    always #5 clk = ~clk;

    // memory model
    logic [DW-1:0]  mem_word = '0;
    logic [DW-1:0]  noise    = '0;
    logic [LAT-1:0] rd_pipe  = '0;
    always @(posedge clk) begin
        rd_pipe <= {rd_pipe[LAT-2:0], mem_rd};
        noise   <= {$urandom, $urandom};
    end
    assign mem_rdata = rd_pipe[LAT-1] ? mem_word : noise;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One store from handshake to done, checked against the model.
    // With hold=1, req_valid stays high with junk fields while the block is busy.
    task automatic run_store(input logic [AW-1:0] addr, input logic [1:0] size,
                             input logic [DW-1:0] data, input logic [DW-1:0] word,
                             input bit hold, output logic [DW-1:0] got_w);
        int            off, n, exp_lat, w;
        bit            trap, full, exp_rd, exp_wr;
        logic [7:0]    b [8];
        logic [DW-1:0] exp_w;
        int            rd_cnt, wr_cnt, rd_cyc, done_cyc, overlap, leak, busy_ready;
        logic [AW-1:0] wr_addr;
        logic          got_err;

        // reference model
        off = int'(addr[2:0]);
        case (size)
            2'b00: n = 8;
            2'b01: n = 4;
            2'b10: n = 2;
            default: n = 1;
        endcase
`ifdef MERGE_ALINH_TRAP_EN
        trap = (off % n) != 0;
`else
        trap = 1'b0;
`endif
        full = (n == 8) && (off == 0);
        for (int i = 0; i < 8; i++) b[i] = word[8*i +: 8];
        for (int k = 0; k < n; k++) begin
            if (off + k < 8) b[off + k] = data[8*k +: 8];
        end
        for (int i = 0; i < 8; i++) exp_w[8*i +: 8] = b[i];
        exp_rd  = !trap && !full;
        exp_wr  = !trap;
        exp_lat = trap ? 1 : (full ? 2 : 3 + LAT);

        // driver
        mem_word = word;
        w = 0;
        @(negedge clk);
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) chk("ready_wait", {63'd0, req_ready}, 64'd1);
        req_addr  = addr;
        req_size  = size;
        req_data  = data;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        if (hold) begin
            req_addr = {$urandom, $urandom};
            req_size = 2'($urandom_range(0, 3));
            req_data = {$urandom, $urandom};
        end else begin
            req_valid = 1'b0;
        end

        // monitor
        rd_cnt = 0; wr_cnt = 0; rd_cyc = 0; done_cyc = 0;
        overlap = 0; leak = 0; busy_ready = 0;
        got_w = '0; wr_addr = '0; got_err = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (mem_rd && mem_wr) overlap++;
            if (!mem_wr && mem_wdata != '0) leak++;
            if (mem_rd) begin
                rd_cnt++;
                rd_cyc = k;
            end
            if (mem_wr) begin
                wr_cnt++;
                got_w   = mem_wdata;
                wr_addr = mem_addr;
            end
            if (req_ready) busy_ready++;
            if (done) begin
                done_cyc = k;
                got_err  = erro_alinh;
                break;
            end
        end

        chk("latency",   64'(done_cyc), 64'(exp_lat));
        chk("rd_count",  64'(rd_cnt),   exp_rd ? 64'd1 : 64'd0);
        chk("wr_count",  64'(wr_cnt),   exp_wr ? 64'd1 : 64'd0);
        chk("erro",      {63'd0, got_err}, {63'd0, trap});
        chk("overlap",   64'(overlap),  64'd0);
        chk("wdata_idle", 64'(leak),    64'd0);
        chk("busy_ready", 64'(busy_ready), 64'd0);
        if (exp_rd) chk("rd_cycle", 64'(rd_cyc), 64'd1);
        if (exp_wr) begin
            chk("wdata",   got_w,   exp_w);
            chk("wr_addr", wr_addr, {addr[AW-1:3], 3'b000});
        end
    endtask

    initial begin
        logic [DW-1:0] got;
        logic [AW-1:0] a;
        logic [1:0]    s;
        int            cnt_bad;

        // reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_rd",    {63'd0, mem_rd},    64'd0);
        chk("rst_wr",    {63'd0, mem_wr},    64'd0);
        chk("rst_done",  {63'd0, done},      64'd0);
        chk("rst_erro",  {63'd0, erro_alinh}, 64'd0);
        chk("rst_addr",  mem_addr,  64'd0);
        chk("rst_wdata", mem_wdata, 64'd0);
        rst_n = 1'b1;

        // directed cases
        run_store(64'h1003, 2'b11, 64'hAB, 64'h1122334455667788, 1'b0, got);
        chk("byte_merge", got, 64'h11223344AB667788);
        run_store(64'h100, 2'b00, 64'hDEADBEEFCAFEF00D, {$urandom, $urandom}, 1'b0, got);
        chk("full_store", got, 64'hDEADBEEFCAFEF00D);
        run_store(64'h207, 2'b10, 64'hBEEF, 64'h0, 1'b0, got);
`ifndef MERGE_ALINH_TRAP_EN
        chk("half_overflow", got, 64'hEF00000000000000);
`endif
        run_store(64'h304, 2'b01, 64'h12345678, 64'hFFFFFFFFFFFFFFFF, 1'b0, got);
        chk("word_merge", got, 64'h12345678FFFFFFFF);

        // randomized stores, some with req_valid held high back-to-back
        for (int t = 0; t < 40; t++) begin
            a = {$urandom, $urandom};
            s = 2'($urandom_range(0, 3));
            if (t % 8 == 0) begin
                a[2:0] = 3'd0;
                s      = 2'b00;
            end
            run_store(a, s, {$urandom, $urandom}, {$urandom, $urandom},
                      bit'($urandom_range(0, 1)), got);
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);

        // reset while waiting for read data
        mem_word  = 64'h0123456789ABCDEF;
        req_addr  = 64'h401;
        req_size  = 2'b11;
        req_data  = 64'h5A;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ready", {63'd0, req_ready}, 64'd1);
        chk("abort_wr",    {63'd0, mem_wr},    64'd0);
        chk("abort_done",  {63'd0, done},      64'd0);
        rst_n = 1'b1;
        cnt_bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (mem_wr || done || mem_rd || !req_ready) cnt_bad++;
        end
        chk("abort_quiet", 64'(cnt_bad), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/merge_escrita_memoria.md
MERGE_ESCRITA_MEMORIA -- requirements
Module: merge_escrita_memoria

Interface
REQ-001 SHALL have parameter DATA_W, default 64, memory word width in bits (multiple of 8, power of two, >= 16).
REQ-002 SHALL have parameter ADDR_W, default 64, byte-address width.
REQ-003 SHALL have parameter MEM_LATENCY, default 1, memory read latency in cycles (>= 1).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  1  store request present.
REQ-007 req_ready  output  1  block can accept a request.
REQ-008 req_addr  input  ADDR_W  store byte address.
REQ-009 req_size  input  2  store size: 00 = DATA_W, 01 = 32 bits, 10 = 16 bits, 11 = 8 bits.
REQ-010 req_data  input  DATA_W  store data, right-aligned.
REQ-011 mem_addr  output  ADDR_W  word-aligned memory address.
REQ-012 mem_rd  output  1  memory read strobe.
REQ-013 mem_rdata  input  DATA_W  memory read data.
REQ-014 mem_wr  output  1  memory write strobe.
REQ-015 mem_wdata  output  DATA_W  merged write word.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 erro_alinh  output  1  misalignment flag, valid while done=1 (constant 0 without MERGE_ALINH_TRAP_EN).

Function
REQ-018 Handshake SHALL occur on a rising edge with req_valid=1 and req_ready=1; req_addr, req_size, req_data SHALL be latched then.
REQ-019 req_ready SHALL be 1 only in state OCIOSO.
REQ-020 States SHALL be OCIOSO, LEITURA, ESPERA, ESCRITA, FIM.
REQ-021 Byte offset off = req_addr modulo DATA_W/8; mem_addr SHALL equal req_addr with the offset bits cleared.
REQ-022 Size 00 with off=0: OCIOSO -> ESCRITA (no read); mem_wdata = req_data.
REQ-023 Otherwise: OCIOSO -> LEITURA (1 cycle, mem_rd=1) -> ESPERA (MEM_LATENCY cycles) -> ESCRITA; mem_rdata SHALL be captured on the edge leaving ESPERA.
REQ-024 Merge: bytes [off, off+n-1] of mem_wdata SHALL be bytes [0, n-1] of req_data (n = size in bytes); all other bytes SHALL equal captured mem_rdata.
REQ-025 Bytes with index off+k >= DATA_W/8 SHALL be discarded (no second word access).
REQ-026 ESCRITA SHALL last 1 cycle with mem_wr=1; then FIM for 1 cycle with done=1; then OCIOSO.
REQ-027 Latency handshake-to-done: 3+MEM_LATENCY cycles for read-merge stores, 2 for full aligned stores.
REQ-028 mem_rd and mem_wr SHALL never be 1 in the same cycle; mem_wdata SHALL be 0 outside ESCRITA.
REQ-029 req_valid held during busy states SHALL be ignored; a new request SHALL be accepted no earlier than the cycle after FIM.
REQ-030 Size 32 with DATA_W=16 SHALL be treated as size 00.

Reset
REQ-031 rst_n=0 at a rising edge SHALL force OCIOSO from any state, aborting the operation with no mem_wr and no done.
REQ-032 Reset values: req_ready=1, mem_rd=0, mem_wr=0, done=0, erro_alinh=0, mem_addr=0, mem_wdata=0, ESPERA counter=0.

Configuration
REQ-033 Macro MERGE_ALINH_TRAP_EN: when defined, a request with off not a multiple of n SHALL go OCIOSO -> FIM directly, with no mem_rd, no mem_wr, done=1 and erro_alinh=1.
REQ-034 Without MERGE_ALINH_TRAP_EN, misaligned requests SHALL merge per REQ-024/025 and erro_alinh SHALL be 0.

Verification
REQ-035 DATA_W=64, mem_rdata=0x1122334455667788, size 11, addr 0x...03, data 0xAB -> mem_wdata=0x11223344AB667788, done 4 cycles after handshake (MEM_LATENCY=1).
REQ-036 Size 00, addr 0x100, data 0xDEADBEEFCAFEF00D -> no mem_rd, mem_wr next cycle with that data, done 2 cycles after handshake.
REQ-037 Size 10, addr offset 7, data 0xBEEF, mem_rdata 0 -> mem_wdata=0xEF00000000000000 (no define); with MERGE_ALINH_TRAP_EN -> no memory strobes, done=1, erro_alinh=1.
REQ-038 MEM_LATENCY=3, size 01, offset 4, data 0x12345678, mem_rdata all 0xFF bytes -> mem_wdata=0x12345678FFFFFFFF, done 6 cycles after handshake.
REQ-039 rst_n=0 in ESPERA -> next cycle OCIOSO, req_ready=1, no mem_wr or done ever issued for that request.
REQ-040 req_valid held high continuously for back-to-back stores -> accepted exactly once per OCIOSO visit, strobes never overlap.
